// File: rtl/axis_adc_decii_pkg.sv
// Shared constants, FSM state type and shift clamp for the ADC block-averaging decimator.
package axis_adc_decii_pkg;

  localparam int unsigned ADC_W     = 24;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned MAX_SHIFT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Exponents above the supported maximum saturate to it.
  function automatic logic [3:0] clamp_shift(input logic [3:0] shift,
                                             input logic [3:0] max_shift);
    return (shift > max_shift) ? max_shift : shift;
  endfunction

endpackage

// File: rtl/adc_decii_acc.sv
// Single-channel block accumulator, result shifter and full-scale detector.
// Optional feature: AXIS_ADC_DECII_OVERRANGE_EN builds the sticky full-scale flag.
module adc_decii_acc import axis_adc_decii_pkg::*; #(
  parameter int unsigned ADC_WIDTH  = ADC_W,
  parameter int unsigned DATA_WIDTH = ACC_W,
  parameter int unsigned SHIFT_MAX  = MAX_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  strobe,
  input  logic                  accept,
  input  logic                  last,
  input  logic                  restart,
  input  logic [3:0]            k_use,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overrange
);

  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic signed [DATA_WIDTH-1:0] sum;
  logic [3:0]                   shamt;
  logic                         unused_lsbs;

  // Sample sits left-justified; sign-extend the ADC word to the accumulator width.
  assign x           = {{(DATA_WIDTH-ADC_WIDTH){sample[DATA_WIDTH-1]}},
                        sample[DATA_WIDTH-1 -: ADC_WIDTH]};
  assign sum         = acc_q + x;
  assign shamt       = 4'(SHIFT_MAX) - k_use;
  assign unused_lsbs = ^sample[DATA_WIDTH-ADC_WIDTH-1:0];

  // Running sum; reloads to zero on the block-ending pair so the next block starts seamlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (restart) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= last ? '0 : sum;
    end
  end

  // Result register: left-justify the block sum so every k gives the same full-scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (accept && last && !restart) begin
      result <= sum << shamt;
    end
  end

`ifdef AXIS_ADC_DECII_OVERRANGE_EN
  logic is_fs;
  logic or_q;

  assign is_fs = (sample[DATA_WIDTH-1 -: ADC_WIDTH] == {1'b0, {(ADC_WIDTH-1){1'b1}}}) ||
                 (sample[DATA_WIDTH-1 -: ADC_WIDTH] == {1'b1, {(ADC_WIDTH-1){1'b0}}});

  // Sticky flag; any strobe counts, paired or not, and restart clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q <= 1'b0;
    end else if (restart) begin
      or_q <= 1'b0;
    end else if (strobe && is_fs) begin
      or_q <= 1'b1;
    end
  end

  assign overrange = or_q;
`else
  logic unused_strobe;

  assign unused_strobe = strobe;
  assign overrange     = 1'b0;
`endif

endmodule

// File: rtl/axis_adc_decii.sv
// Dual-channel block-averaging decimator for the AD463x sample streams (tvalid-only AXIS).
// Optional feature: AXIS_ADC_DECII_OVERRANGE_EN enables the sticky overrange flags.
module axis_adc_decii #(
  parameter int unsigned ADC_DATA_WIDTH    = 24,
  parameter int unsigned SAXIS_TDATA_WIDTH = 32,
  parameter int unsigned MAX_SHIFT         = 8
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS1_tdata,
  input  logic                         S_AXIS1_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS2_tdata,
  input  logic                         S_AXIS2_tvalid,
  input  logic [3:0]                   decii_shift,
  input  logic                         restart,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS1_tdata,
  output logic                         M_AXIS1_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS2_tdata,
  output logic                         M_AXIS2_tvalid,
  output logic [15:0]                  pair_errors,
  output logic [1:0]                   overrange
);

  import axis_adc_decii_pkg::*;

  localparam int unsigned CNT_W = MAX_SHIFT + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] blk_last_cnt;
  logic [3:0]       k_q;
  logic [3:0]       k_next;
  logic [3:0]       k_use;
  logic             accept;
  logic             unpaired;
  logic             last;
  logic             valid_q;
  logic [15:0]      perr_q;

  assign accept   = S_AXIS1_tvalid & S_AXIS2_tvalid;
  assign unpaired = S_AXIS1_tvalid ^ S_AXIS2_tvalid;
  assign k_next   = clamp_shift(decii_shift, 4'(MAX_SHIFT));
  // While idle the live exponent applies, so the first pair of a block already sees it.
  assign k_use        = (state_q == IDLE) ? k_next : k_q;
  assign blk_last_cnt = (CNT_W'(1) << k_use) - CNT_W'(1);
  assign last         = (cnt_q == blk_last_cnt);

  // Block FSM: pair counter, exponent latch and the one-cycle result strobe.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (restart) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        k_q     <= k_next;
      end else if (accept) begin
        state_q <= ACC;
        if (last) begin
          cnt_q   <= '0;
          k_q     <= k_next;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          k_q   <= k_use;
        end
      end else if (state_q == IDLE) begin
        k_q <= k_next;
      end
    end
  end

  // Saturating count of strobes that arrived without a partner; only reset clears it.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      perr_q <= '0;
    end else if (unpaired && (perr_q != 16'hFFFF)) begin
      perr_q <= perr_q + 16'd1;
    end
  end

  adc_decii_acc #(
    .ADC_WIDTH  (ADC_DATA_WIDTH),
    .DATA_WIDTH (SAXIS_TDATA_WIDTH),
    .SHIFT_MAX  (MAX_SHIFT)
  ) u_acc_ch1 (
    .clk       (a_clk),
    .rst       (a_rst),
    .sample    (S_AXIS1_tdata),
    .strobe    (S_AXIS1_tvalid),
    .accept    (accept),
    .last      (last),
    .restart   (restart),
    .k_use     (k_use),
    .result    (M_AXIS1_tdata),
    .overrange (overrange[0])
  );

  adc_decii_acc #(
    .ADC_WIDTH  (ADC_DATA_WIDTH),
    .DATA_WIDTH (SAXIS_TDATA_WIDTH),
    .SHIFT_MAX  (MAX_SHIFT)
  ) u_acc_ch2 (
    .clk       (a_clk),
    .rst       (a_rst),
    .sample    (S_AXIS2_tdata),
    .strobe    (S_AXIS2_tvalid),
    .accept    (accept),
    .last      (last),
    .restart   (restart),
    .k_use     (k_use),
    .result    (M_AXIS2_tdata),
    .overrange (overrange[1])
  );

  assign M_AXIS1_tvalid = valid_q;
  assign M_AXIS2_tvalid = valid_q;
  assign pair_errors    = perr_q;

endmodule

// File: tb/tb_axis_adc_decii.sv
// Self-checking bench for axis_adc_decii: behavioural block-average model plus directed literals.
module tb_axis_adc_decii;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [31:0] s1d = '0;
  logic [31:0] s2d = '0;
  logic        s1v = 1'b0;
  logic        s2v = 1'b0;
  logic [3:0]  shift = '0;
  logic        restart = 1'b0;
  logic [31:0] m1d;
  logic [31:0] m2d;
  logic        m1v;
  logic        m2v;
  logic [15:0] pair_errors;
  logic [1:0]  overrange;

  always #5 a_clk = ~a_clk;

  axis_adc_decii dut (
    .a_clk          (a_clk),
    .a_rst          (a_rst),
    .S_AXIS1_tdata  (s1d),
    .S_AXIS1_tvalid (s1v),
    .S_AXIS2_tdata  (s2d),
    .S_AXIS2_tvalid (s2v),
    .decii_shift    (shift),
    .restart        (restart),
    .M_AXIS1_tdata  (m1d),
    .M_AXIS1_tvalid (m1v),
    .M_AXIS2_tdata  (m2d),
    .M_AXIS2_tvalid (m2v),
    .pair_errors    (pair_errors),
    .overrange      (overrange)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_idle = 1'b1;
  int          m_k = 0;
  int          m_cnt = 0;
  longint      m_s1 = 0;
  longint      m_s2 = 0;
  logic        m_v = 1'b0;
  logic [31:0] m_d1 = '0;
  logic [31:0] m_d2 = '0;
  int          m_perr = 0;
  logic [1:0]  m_or = '0;

  function automatic int clampk(input logic [3:0] s);
    return (s > 4'd8) ? 8 : int'(s);
  endfunction

  function automatic longint sx(input logic [31:0] d);
    logic signed [23:0] x;
    x = d[31:8];
    return longint'(x);
  endfunction

  function automatic bit is_fs(input logic [31:0] d);
    return (d[31:8] == 24'h7FFFFF) || (d[31:8] == 24'h800000);
  endfunction

  initial forever begin
    @(posedge a_clk or posedge a_rst);
    if (a_rst) begin
      m_idle = 1'b1; m_k = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
      m_v = 1'b0; m_d1 = '0; m_d2 = '0; m_perr = 0; m_or = '0;
    end else begin
      m_v = 1'b0;
      if ((s1v ^ s2v) && m_perr < 65535) m_perr++;
`ifdef AXIS_ADC_DECII_OVERRANGE_EN
      if (restart) m_or = '0;
      else begin
        if (s1v && is_fs(s1d)) m_or[0] = 1'b1;
        if (s2v && is_fs(s2d)) m_or[1] = 1'b1;
      end
`endif
      if (restart) begin
        m_idle = 1'b1; m_cnt = 0; m_s1 = 0; m_s2 = 0;
      end else if (s1v && s2v) begin
        if (m_idle) begin
          m_k    = clampk(shift);
          m_idle = 1'b0;
        end
        m_s1 += sx(s1d);
        m_s2 += sx(s2d);
        m_cnt++;
        if (m_cnt == (1 << m_k)) begin
          // Mean scaled back to a 32-bit left-justified word.
          m_d1  = 32'(m_s1 * (64'sd1 << (8 - m_k)));
          m_d2  = 32'(m_s2 * (64'sd1 << (8 - m_k)));
          m_v   = 1'b1;
          m_s1  = 0;
          m_s2  = 0;
          m_cnt = 0;
          m_k   = clampk(shift);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          n_strobes = 0;
  logic [31:0] last_d1 = '0;
  logic [31:0] last_d2 = '0;
  logic [31:0] prev_d1 = '0;

  initial forever begin
    @(negedge a_clk);
    check("tvalid1", {31'b0, m1v}, {31'b0, m_v});
    check("tvalid2", {31'b0, m2v}, {31'b0, m_v});
    check("tdata1", m1d, m_d1);
    check("tdata2", m2d, m_d2);
    check("pair_errors", {16'b0, pair_errors}, 32'(m_perr));
    check("overrange", {30'b0, overrange}, {30'b0, m_or});
    if (m1v) begin
      n_strobes++;
      prev_d1 = last_d1;
      last_d1 = m1d;
      last_d2 = m2d;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v1, input logic [31:0] d1, input logic v2,
                     input logic [31:0] d2, input logic rs);
    s1v = v1; s1d = d1; s2v = v2; s2d = d2; restart = rs;
    @(posedge a_clk);
    #2;
  endtask

  task automatic pair(input logic [31:0] d1, input logic [31:0] d2);
    cyc(1'b1, d1, 1'b1, d2, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_restart(input logic [3:0] sh);
    shift = sh;
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 15) == 0) r = ($urandom_range(0, 1) == 0) ? 32'h7FFFFF00 : 32'h80000000;
    return r;
  endfunction

  initial begin
    int base;
    int r;
    logic [1:0] or_exp;

    repeat (3) @(posedge a_clk);
    #2;
    check("reset_tvalid", {31'b0, m1v}, 32'd0);
    check("reset_tdata1", m1d, 32'd0);
    check("reset_perr", {16'b0, pair_errors}, 32'd0);
    check("reset_overrange", {30'b0, overrange}, 32'd0);
    a_rst = 1'b0;

    // k=2 averaging of a positive and a negative constant
    do_restart(4'd2);
    base = n_strobes;
    repeat (4) pair(32'h00010000, 32'hFFFF0000);
    idle(2);
    check("k2_count", 32'(n_strobes - base), 32'd1);
    check("k2_d1", last_d1, 32'h00010000);
    check("k2_d2", last_d2, 32'hFFFF0000);

    // k=0 pass-through, back to back
    do_restart(4'd0);
    base = n_strobes;
    pair(32'hFFFFFF00, 32'hFFFFFF00);
    pair(32'h00000100, 32'h00000100);
    idle(2);
    check("k0_count", 32'(n_strobes - base), 32'd2);
    check("k0_first", prev_d1, 32'hFFFFFF00);
    check("k0_second", last_d1, 32'h00000100);

    // k=8 full-scale block
    do_restart(4'd8);
    base = n_strobes;
    repeat (256) pair(32'h7FFFFF00, 32'h7FFFFF00);
    idle(2);
    check("k8_count", 32'(n_strobes - base), 32'd1);
    check("k8_d1", last_d1, 32'h7FFFFF00);
    check("k8_d2", last_d2, 32'h7FFFFF00);
`ifdef AXIS_ADC_DECII_OVERRANGE_EN
    or_exp = 2'b11;
`else
    or_exp = 2'b00;
`endif
    check("k8_overrange", {30'b0, overrange}, {30'b0, or_exp});
    do_restart(4'd1);
    check("restart_overrange", {30'b0, overrange}, 32'd0);

    // unpaired strobes at k=1
    base = n_strobes;
    repeat (3) cyc(1'b1, 32'h00000400, 1'b0, '0, 1'b0);
    check("unpaired_perr", {16'b0, pair_errors}, 32'd3);
    idle(1);
    check("unpaired_no_out", 32'(n_strobes - base), 32'd0);
    repeat (2) pair(32'h00000400, 32'h00000400);
    idle(2);
    check("unpaired_count", 32'(n_strobes - base), 32'd1);
    check("unpaired_d1", last_d1, 32'h00000400);

    // exponent change mid-block takes effect at the boundary
    do_restart(4'd2);
    base = n_strobes;
    repeat (2) pair(32'h00000100, 32'h00000100);
    shift = 4'd1;
    repeat (2) pair(32'h00000100, 32'h00000100);
    idle(1);
    check("kchg_first_count", 32'(n_strobes - base), 32'd1);
    check("kchg_first_d1", last_d1, 32'h00000100);
    repeat (2) pair(32'h00000300, 32'h00000300);
    idle(2);
    check("kchg_second_count", 32'(n_strobes - base), 32'd2);
    check("kchg_second_d1", last_d1, 32'h00000300);

    // restart aborts a partial block
    do_restart(4'd2);
    base = n_strobes;
    repeat (3) pair(32'h00050000, 32'h00050000);
    do_restart(4'd2);
    repeat (4) pair(32'h00020000, 32'h00020000);
    idle(2);
    check("abort_count", 32'(n_strobes - base), 32'd1);
    check("abort_d1", last_d1, 32'h00020000);

    // exponent above the maximum clamps to 8
    do_restart(4'd15);
    base = n_strobes;
    repeat (256) pair(32'h00000100, 32'hFFFFFE00);
    idle(2);
    check("clamp_count", 32'(n_strobes - base), 32'd1);
    check("clamp_d1", last_d1, 32'h00000100);
    check("clamp_d2", last_d2, 32'hFFFFFE00);

    // reset right after a block end suppresses the pending strobe
    do_restart(4'd2);
    base = n_strobes;
    repeat (4) pair(32'h00030000, 32'h00030000);
    a_rst = 1'b1;
    #1;
    check("rst_tvalid", {31'b0, m1v}, 32'd0);
    check("rst_tdata1", m1d, 32'd0);
    check("rst_perr", {16'b0, pair_errors}, 32'd0);
    idle(1);
    a_rst = 1'b0;
    idle(1);
    check("rst_no_strobe", 32'(n_strobes - base), 32'd0);

    // randomized traffic
    shift = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) shift = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 2) do_restart(4'($urandom_range(0, 15)));
      else if (r < 85) pair(pick(), pick());
      else if (r < 90) cyc(1'b1, pick(), 1'b0, pick(), 1'b0);
      else if (r < 93) cyc(1'b0, pick(), 1'b1, pick(), 1'b0);
      else idle(1);
    end

    // pair_errors saturation
    a_rst = 1'b1;
    idle(1);
    a_rst = 1'b0;
    repeat (65540) cyc(1'b0, '0, 1'b1, 32'h00000100, 1'b0);
    check("perr_saturate", {16'b0, pair_errors}, 32'h0000FFFF);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
